// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin arbiter sharing one look-ahead adder stage
// Issues one tagged operand transfer per cycle and routes each returning sum to its requester.
module adder_share_arbiter #(
  parameter int SIZE              = 8,
  parameter int NUM_REQ           = 4,
  parameter int PASS_THROUGH_SIZE = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*SIZE-1:0]      req_a,
  input  logic [NUM_REQ*SIZE-1:0]      req_b,
  input  logic [NUM_REQ-1:0]           req_cin,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [SIZE-1:0]              rsp_sum,
  output logic                         rsp_carry,
  output logic                         add_load,
  output logic [SIZE-1:0]              add_input_1,
  output logic [SIZE-1:0]              add_input_2,
  output logic                         add_carry_in,
  output logic [PASS_THROUGH_SIZE-1:0] add_passthrough_in,
  input  logic                         add_load_out,
  input  logic [SIZE-1:0]              add_sum,
  input  logic                         add_carry,
  input  logic [PASS_THROUGH_SIZE-1:0] add_passthrough_out,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic [2:0]                   outstanding,
  output logic                         err
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] next_ptr;
  logic [ID_W-1:0] ret_id;
  logic            win_found;
  logic            transfer;
  logic            ret_marker;
  logic            ret_id_ok;
  logic            ret_valid;
  logic            ret_bad;
  logic            unused_pt_hi;
  int              scan_idx;

  // Scan requesters starting at the round-robin pointer, wrapping past NUM_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!win_found && req[ID_W'(scan_idx)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(scan_idx);
      end
    end
  end

  // Grant is forced low while reset is asserted so every output reads zero in reset.
  assign transfer = reset && (state == ST_RUN) && win_found;
  assign grant    = transfer ? (NUM_REQ'(1) << win_id) : '0;
  assign next_ptr = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

  assign ret_marker   = add_passthrough_out[ID_W];
  assign ret_id       = add_passthrough_out[ID_W-1:0];
  assign unused_pt_hi = ^add_passthrough_out[PASS_THROUGH_SIZE-1:ID_W+1];

  generate
    if (NUM_REQ == (1 << ID_W)) begin : g_id_full
      assign ret_id_ok = 1'b1;
    end else begin : g_id_part
      assign ret_id_ok = (ret_id < ID_W'(NUM_REQ));
    end
  endgenerate

  assign ret_valid = add_load_out && ret_marker && ret_id_ok && (outstanding != 3'd0);
  assign ret_bad   = add_load_out && !ret_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr             <= '0;
      add_load           <= 1'b0;
      add_input_1        <= '0;
      add_input_2        <= '0;
      add_carry_in       <= 1'b0;
      add_passthrough_in <= '0;
      rsp_valid          <= '0;
      rsp_sum            <= '0;
      rsp_carry          <= 1'b0;
      outstanding        <= '0;
      err                <= 1'b0;
    end else begin
      add_load <= transfer;
      if (transfer) begin
        add_input_1        <= req_a[int'(win_id)*SIZE +: SIZE];
        add_input_2        <= req_b[int'(win_id)*SIZE +: SIZE];
        add_carry_in       <= req_cin[win_id];
        add_passthrough_in <= PASS_THROUGH_SIZE'({1'b1, win_id});
        rr_ptr             <= next_ptr;
      end
      rsp_valid <= ret_valid ? (NUM_REQ'(1) << ret_id) : '0;
      if (ret_valid) begin
        rsp_sum   <= add_sum;
        rsp_carry <= add_carry;
      end
      if (transfer && !ret_valid) begin
        outstanding <= outstanding + 3'd1;
      end else if (!transfer && ret_valid) begin
        outstanding <= outstanding - 3'd1;
      end
      if (ret_bad) err <= 1'b1;
    end
  end

  // Drain completes only once nothing is in flight and no load is headed into the stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RUN;
      flush_done <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush_req) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((outstanding == 3'd0) && !add_load) begin
            state      <= ST_IDLE;
            flush_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (!flush_req) begin
            state      <= ST_RUN;
            flush_done <= 1'b0;
          end
        end
        default: begin
          state      <= ST_RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - scoreboard bench for adder_share_arbiter with a two-register stage model
module tb_adder_share_arbiter;
  localparam int SIZE    = 8;
  localparam int NUM_REQ = 4;
  localparam int PTS     = 16;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [NUM_REQ-1:0]      req = '0;
  logic [NUM_REQ*SIZE-1:0] req_a = '0;
  logic [NUM_REQ*SIZE-1:0] req_b = '0;
  logic [NUM_REQ-1:0]      req_cin = '0;
  logic [NUM_REQ-1:0]      grant;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [SIZE-1:0]         rsp_sum;
  logic                    rsp_carry;
  logic                    add_load;
  logic [SIZE-1:0]         add_input_1;
  logic [SIZE-1:0]         add_input_2;
  logic                    add_carry_in;
  logic [PTS-1:0]          add_passthrough_in;
  logic                    add_load_out;
  logic [SIZE-1:0]         add_sum;
  logic                    add_carry;
  logic [PTS-1:0]          add_passthrough_out;
  logic                    flush_req = 1'b0;
  logic                    flush_done;
  logic [2:0]              outstanding;
  logic                    err;
  logic                    inj = 1'b0;

  typedef struct {
    int              id;
    logic [SIZE-1:0] sum;
    logic            carry;
    int              cyc;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [SIZE:0] mon_s;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            max_out = 0;

  // Stand-in for the shared adder stage: capture register then output register.
  logic            s1_v, st_lo, st_c, s1_cin;
  logic [SIZE-1:0] s1_a, s1_b, st_s;
  logic [PTS-1:0]  s1_pt, st_pt;

  adder_share_arbiter #(.SIZE(SIZE), .NUM_REQ(NUM_REQ), .PASS_THROUGH_SIZE(PTS)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .add_load(add_load), .add_input_1(add_input_1), .add_input_2(add_input_2),
    .add_carry_in(add_carry_in), .add_passthrough_in(add_passthrough_in),
    .add_load_out(add_load_out), .add_sum(add_sum), .add_carry(add_carry),
    .add_passthrough_out(add_passthrough_out), .flush_req(flush_req),
    .flush_done(flush_done), .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v <= 1'b0; s1_a <= '0; s1_b <= '0; s1_cin <= 1'b0; s1_pt <= '0;
      st_lo <= 1'b0; st_s <= '0; st_c <= 1'b0; st_pt <= '0;
    end else begin
      s1_v <= add_load; s1_a <= add_input_1; s1_b <= add_input_2;
      s1_cin <= add_carry_in; s1_pt <= add_passthrough_in;
      st_lo <= s1_v; st_pt <= s1_pt;
      {st_c, st_s} <= {1'b0, s1_a} + {1'b0, s1_b} + {{SIZE{1'b0}}, s1_cin};
    end
  end

  assign add_load_out        = inj ? 1'b1 : st_lo;
  assign add_passthrough_out = inj ? '0 : st_pt;
  assign add_sum             = st_s;
  assign add_carry           = st_c;

  // Scoreboard: push on visible grant, pop on result strobe; result due 4 cycle ticks later.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && grant[i]) begin
          mon_s = {1'b0, req_a[i*SIZE +: SIZE]} + {1'b0, req_b[i*SIZE +: SIZE]} + {{SIZE{1'b0}}, req_cin[i]};
          sb_q.push_back('{i, mon_s[SIZE-1:0], mon_s[SIZE], cyc});
        end
      end
      if (rsp_valid != '0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected rsp_valid=%b required none", rsp_valid);
        end else begin
          mon_e = sb_q.pop_front();
          if (rsp_valid !== (4'b0001 << mon_e.id) || rsp_sum !== mon_e.sum ||
              rsp_carry !== mon_e.carry || cyc != mon_e.cyc + 4) begin
            errors++;
            $display("FAIL rsp_match got vec=%b sum=%h c=%b cyc=%0d required vec=%b sum=%h c=%b cyc=%0d",
                     rsp_valid, rsp_sum, rsp_carry, cyc, 4'b0001 << mon_e.id, mon_e.sum, mon_e.carry, mon_e.cyc + 4);
          end
        end
      end
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
    end
  end

  task automatic do_reset();
    reset = 1'b0; req = '0; flush_req = 1'b0; inj = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '1; req_a = 32'hA5A5_A5A5; req_b = 32'h1234_5678; req_cin = '1;
    @(negedge clk);
    checks++;
    if (grant !== '0) begin errors++; $display("FAIL reset_grant got %b required 0000", grant); end
    checks++;
    if ({rsp_valid, rsp_sum, rsp_carry, add_load, add_input_1, add_input_2, add_carry_in} !== '0) begin
      errors++; $display("FAIL reset_data got rsp_valid=%b rsp_sum=%h add_load=%b required all 0", rsp_valid, rsp_sum, add_load);
    end
    checks++;
    if ({add_passthrough_in, flush_done, outstanding, err} !== '0) begin
      errors++; $display("FAIL reset_ctrl got pt=%h fd=%b out=%0d err=%b required all 0", add_passthrough_in, flush_done, outstanding, err);
    end
    req = '0;
  endtask

  task automatic test_single_op();
    do_reset();
    req = 4'b0100; req_a[2*SIZE +: SIZE] = 8'hF0; req_b[2*SIZE +: SIZE] = 8'h20; req_cin[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b required 0100", grant); end
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    checks++;
    if ({add_load, add_input_1, add_input_2, add_carry_in, add_passthrough_in, outstanding} !==
        {1'b1, 8'hF0, 8'h20, 1'b1, 16'h0006, 3'd1}) begin
      errors++; $display("FAIL single_issue got load=%b a=%h b=%h pt=%h out=%0d required 1 f0 20 0006 1",
                         add_load, add_input_1, add_input_2, add_passthrough_in, outstanding);
    end
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) begin @(negedge clk); #1; end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL single_timeout pending=%0d required 0", sb_q.size()); end
    checks++;
    if ({rsp_sum, rsp_carry, outstanding} !== {8'h11, 1'b1, 3'd0}) begin
      errors++; $display("FAIL single_result got sum=%h c=%b out=%0d required 11 1 0", rsp_sum, rsp_carry, outstanding);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    int         g;
    do_reset();
    max_out = 0;
    for (int i = 0; i < NUM_REQ*SIZE; i++) begin req_a[i] = 1'($urandom); req_b[i] = 1'($urandom); end
    req_cin = 4'($urandom);
    req = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_g = 4'b0001 << (k % 4);
      checks++;
      if (grant !== exp_g) begin errors++; $display("FAIL fair_grant_%0d got %b required %b", k, grant, exp_g); end
      g = k % 4;
      @(posedge clk); #1;
      req_a[g*SIZE +: SIZE] = 8'($urandom);
      req_b[g*SIZE +: SIZE] = 8'($urandom);
      req_cin[g] = 1'($urandom);
    end
    req = '0;
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) begin @(negedge clk); #1; end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL fair_timeout pending=%0d required 0", sb_q.size()); end
    checks++;
    if (max_out != 3) begin errors++; $display("FAIL fair_peak got %0d required 3", max_out); end
  endtask

  task automatic test_wrap_skip();
    logic [3:0] seq [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    do_reset();
    req_a = 32'h0102_0304; req_b = 32'h1020_3040; req_cin = 4'b1010;
    req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== seq[k]) begin errors++; $display("FAIL wrap_grant_%0d got %b required %b", k, grant, seq[k]); end
      @(posedge clk); #1;
    end
    req = 4'b0011;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_ptr got %b required 0001", grant); end
    @(posedge clk); #1 req = '0;
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) begin @(negedge clk); #1; end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL wrap_timeout pending=%0d required 0", sb_q.size()); end
  endtask

  task automatic test_flush();
    int done_at;
    do_reset();
    req_a = 32'hFF10_8001; req_b = 32'h0120_7FFF; req_cin = 4'b0110;
    req = '1;
    repeat (5) @(posedge clk);
    #1 flush_req = 1'b1;
    @(negedge clk);
    checks++;
    if (!$onehot(grant)) begin errors++; $display("FAIL flush_last_grant got %b required one-hot", grant); end
    @(posedge clk);
    done_at = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      checks++;
      if (grant !== '0) begin errors++; $display("FAIL flush_no_grant_%0d got %b required 0000", n, grant); end
      if (flush_done && done_at == 0) done_at = n;
    end
    checks++;
    if (done_at != 5) begin errors++; $display("FAIL flush_done_time got %0d required 5", done_at); end
    checks++;
    if (sb_q.size() != 0 || outstanding !== 3'd0) begin
      errors++; $display("FAIL flush_drained got pending=%0d out=%0d required 0 0", sb_q.size(), outstanding);
    end
    @(posedge clk); #1 flush_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!$onehot(grant) || flush_done !== 1'b0) begin
      errors++; $display("FAIL flush_resume got grant=%b fd=%b required one-hot 0", grant, flush_done);
    end
    @(posedge clk); #1 req = '0;
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) begin @(negedge clk); #1; end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL flush_timeout pending=%0d required 0", sb_q.size()); end
  endtask

  task automatic test_error();
    do_reset();
    @(posedge clk); #1 inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0;
    @(negedge clk);
    checks++;
    if ({err, rsp_valid, outstanding} !== {1'b1, 4'b0000, 3'd0}) begin
      errors++; $display("FAIL err_set got err=%b rsp_valid=%b out=%0d required 1 0000 0", err, rsp_valid, outstanding);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b required 1", err); end
    do_reset();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b required 0", err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_a = 32'h1122_3344; req_b = 32'h5566_7788; req_cin = 4'b0101;
    req = '1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({grant, add_load, outstanding, rsp_valid, add_input_1, add_passthrough_in} !== '0) begin
      errors++; $display("FAIL async_reset got grant=%b load=%b out=%0d rsp=%b a=%h pt=%h required all 0",
                         grant, add_load, outstanding, rsp_valid, add_input_1, add_passthrough_in);
    end
    sb_q.delete();
    req = 4'b0110;
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL async_first_grant got %b required 0010", grant); end
    @(posedge clk); #1 req = '0;
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) begin @(negedge clk); #1; end
    checks++;
    if (sb_q.size() != 0 || err !== 1'b0) begin
      errors++; $display("FAIL async_after got pending=%0d err=%b required 0 0", sb_q.size(), err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_op();
    test_fairness();
    test_wrap_skip();
    test_flush();
    test_error();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and sequencer that shares one `look_ahead_pass_through` adder stage between `NUM_REQ` requesters. It accepts operand transfers over a valid/grant handshake and issues at most one per cycle into the stage. The requester ID travels in the stage's passthrough field, and the arbiter routes each returning sum back to its requester. It also tracks in-flight operations and supports a drain/flush sequence used before reconfiguration or power-down of the datapath.

## Interface
- `SIZE`, 8, operand/sum width; must equal the stage's `SIZE`.
- `NUM_REQ`, 4, number of requesters, 2..8.
- `PASS_THROUGH_SIZE`, 16, stage passthrough width; must be ≥ ID_W+1.
- `ID_W`, derived `$clog2(NUM_REQ)`, requester ID width.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester valid.
- `req_a`, `req_b`  in  NUM_REQ*SIZE  operands, slice i = bits [i*SIZE +: SIZE].
- `req_cin`  in  NUM_REQ  per-requester carry in.
- `grant`  out  NUM_REQ  one-hot ready; combinational from `req`, pointer and state.
- `rsp_valid`  out  NUM_REQ  one-hot, registered, one-cycle result strobe.
- `rsp_sum`  out  SIZE  registered result, shared by all requesters.
- `rsp_carry`  out  1  registered carry out.
- `add_load`, `add_input_1`, `add_input_2`, `add_carry_in`, `add_passthrough_in`  out  1/SIZE/SIZE/1/PASS_THROUGH_SIZE  registered drive to the stage.
- `add_load_out`, `add_sum`, `add_carry`, `add_passthrough_out`  in  1/SIZE/1/PASS_THROUGH_SIZE  stage outputs.
- `flush_req`  in  1  level; requests drain.
- `flush_done`  out  1  registered; high while in IDLE.
- `outstanding`  out  3  in-flight count.
- `err`  out  1  sticky protocol error.

## Operation
- **Reset values.** All outputs 0. Pointer `rr_ptr` is 0. State is RUN.
- **Arbitration.**
  - In RUN, `grant[i]` goes high for the first i with `req[i]`=1, searching from `rr_ptr` upward and wrapping.
  - At most one grant bit is high. No grant is issued in DRAIN or IDLE.
- **Transfer.**
  - A transfer happens on an edge where `req[i] & grant[i]`.
  - At that edge:
    - `add_input_1`/`add_input_2`/`add_carry_in` load slice i.
    - `add_passthrough_in` = {zeros, 1'b1, i[ID_W-1:0]}; bit ID_W is the marker.
    - `add_load` is set to 1 for one cycle.
    - `rr_ptr` becomes (i+1) mod NUM_REQ.
  - With no transfer: `add_load`=0, data registers hold, `rr_ptr` holds.
- **Requester rule.** Operands must be held stable while `req` is high; `req` may drop after the transfer edge.
- **Return.**
  - On an edge with `add_load_out`=1 and a valid passthrough: `rsp_sum`/`rsp_carry` load `add_sum`/`add_carry`, and `rsp_valid[id]`=1 for one cycle.
  - Valid passthrough means: marker set, id < NUM_REQ, and `outstanding` > 0.
  - Otherwise `rsp_valid` is 0 and `rsp_sum`/`rsp_carry` hold.
- **Outstanding counter.** +1 on transfer, −1 on valid return; unchanged when both happen on the same edge. The maximum is 3 by construction; it never wraps.
- **Error.** `err` is set and held until reset on any of:
  - `add_load_out`=1 with marker 0;
  - `add_load_out`=1 with id ≥ NUM_REQ;
  - `add_load_out`=1 with `outstanding`=0. That return is dropped.
- **State machine.**
  - RUN→DRAIN when `flush_req`=1. Sampled at the edge, so a grant visible in that cycle may still transfer.
  - DRAIN→IDLE when `outstanding`=0 and `add_load`=0.
  - IDLE→RUN when `flush_req`=0.
  - If `flush_req` drops during DRAIN, the drain still completes to IDLE, then the block returns to RUN on the next edge.
- **Reset mid-operation.** In-flight results are lost. The stage must be reset together with this block; any stale `add_load_out` after reset raises `err`.

## Timing
- Transfer edge T.
- `add_load`=1 in cycle T..T+1; the stage captures at T+1.
- Stage `load_out`=1 in cycle T+2..T+3.
- `rsp_valid`=1 in cycle T+3..T+4. Latency is 3 edges from transfer to result strobe.
- Throughput is one transfer per cycle.
- A single continuously requesting requester with no competitors is granted every cycle.
- With N requesters all requesting, each is granted exactly once per N cycles.
- `flush_done` asserts on the edge after the drain condition is met. With 3 in flight at flush, DRAIN lasts at most 4 cycles.

## Test plan
- **Single op.** After reset, req[2]=1, a=8'hF0, b=8'h20, cin=1 → grant[2] at the first edge; 3 edges later rsp_valid=4'b0100, rsp_sum=8'h11, rsp_carry=1, and outstanding returns to 0.
- **Fairness.** All 4 requesting for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. Responses return in the same order, each with its own sum. outstanding peaks at 3.
- **Pointer wrap and skip.** With only req[1] and req[3] high → grants alternate 1,3,1,3. rr_ptr after a grant to 3 is 0.
- **Flush.** flush_req raised during back-to-back traffic → no grants after entering DRAIN, all in-flight responses still delivered, flush_done=1 once outstanding=0. Dropping flush_req → grants resume the next cycle.
- **Error.** Force add_load_out=1 with passthrough=0 → err=1 and no rsp_valid; err stays high until reset.
- **Async reset mid-op.** reset low during traffic → all outputs 0 immediately, without waiting for a clock edge; after release, the first grant goes to the lowest requesting index.
